// File: rtl/mem_tg_pkg.sv
// mem_tg_pkg: shared widths, FSM states and the address-derived data pattern.
package mem_tg_pkg;
   localparam int MEM_ROW_ADDR_WIDTH = 15;
   localparam int MEM_COL_ADDR_WIDTH = 10;
   localparam int MEM_BADDR_WIDTH    = 3;
   localparam int MEM_DQ_WIDTH       = 32;
   localparam int CTRL_ADDR_WIDTH    = MEM_ROW_ADDR_WIDTH + MEM_COL_ADDR_WIDTH + MEM_BADDR_WIDTH;
   localparam int DATA_WIDTH         = MEM_DQ_WIDTH * 8;
   localparam int LANES              = DATA_WIDTH / 32;

   typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, DONE} tg_state_t;

   function automatic logic [DATA_WIDTH-1:0] tg_pattern(input logic [31:0] seed,
                                                        input logic [CTRL_ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*32 +: 32] = seed + 32'(addr) + 32'(k);
      return w;
   endfunction
endpackage

// File: rtl/mem_tg_checker.sv
// mem_tg_checker: in-order read-beat checker with sticky error and saturating error count.
// TG_ERR_LOG_EN adds capture of the first mismatching address and data.
module mem_tg_checker
   import mem_tg_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       active,
   input  logic [CTRL_ADDR_WIDTH-1:0] base,
   input  logic [15:0]                nw,
   input  logic [31:0]                seed,
   input  logic                       rvld,
   input  logic [DATA_WIDTH-1:0]      rdout,
   output logic [16:0]                chk_idx,
   output logic                       err,
   output logic [15:0]                err_cnt
`ifdef TG_ERR_LOG_EN
   ,
   output logic [CTRL_ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0]      first_err_data
`endif
);
   logic beat, spur, mism;
   logic [CTRL_ADDR_WIDTH-1:0] exp_addr;
   always_comb begin
      exp_addr = base + CTRL_ADDR_WIDTH'(chk_idx);
      beat     = active && rvld;
      spur     = chk_idx == {1'b0, nw};
      mism     = !spur && rdout != tg_pattern(seed, exp_addr);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         chk_idx <= '0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (clr) begin
         chk_idx <= '0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (beat && !spur) chk_idx <= chk_idx + 17'd1;
         if (beat && (spur || mism)) begin
            err     <= 1'b1;
            err_cnt <= err_cnt + 16'(err_cnt != 16'hFFFF);
         end
      end
`ifdef TG_ERR_LOG_EN
   logic logged;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         logged         <= 1'b0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (clr) begin
         logged         <= 1'b0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (beat && mism && !logged) begin
         logged         <= 1'b1;
         first_err_addr <= exp_addr;
         first_err_data <= rdout;
      end
`endif
endmodule

// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: write-then-readback traffic generator with in-order checking and drain timeout.
// TG_ERR_LOG_EN exposes first_err_addr/first_err_data.
module mem_traffic_gen
   import mem_tg_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CTRL_ADDR_WIDTH-1:0] start_addr,
   input  logic [15:0]                num_words,
   input  logic [31:0]                seed,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       timeout,
   output logic [15:0]                err_cnt,
   output logic                       wen,
   output logic [MEM_DQ_WIDTH-1:0]    wb,
   output logic [DATA_WIDTH-1:0]      wdin,
   output logic [CTRL_ADDR_WIDTH-1:0] waddr,
   output logic                       ren,
   output logic [CTRL_ADDR_WIDTH-1:0] raddr,
   input  logic                       rvld,
   input  logic [DATA_WIDTH-1:0]      rdout
`ifdef TG_ERR_LOG_EN
   ,
   output logic [CTRL_ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0]      first_err_data
`endif
);
   localparam int TW = $clog2(TIMEOUT + 1);
   tg_state_t state, nxt;
   logic [CTRL_ADDR_WIDTH-1:0] base, cur_addr;
   logic [15:0] nw, idx;
   logic [31:0] seed_q;
   logic [TW-1:0] timer;
   logic [16:0] chk_idx;
   logic start_ok, last, drained, tmo_hit, chk_err;
   always_comb begin
      start_ok = start && (state == IDLE || state == DONE);
      last     = idx == nw - 16'd1;
      drained  = chk_idx == {1'b0, nw};
      tmo_hit  = state == DRAIN && !drained && !rvld && timer == TW'(TIMEOUT - 1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: if (start) nxt = num_words == 16'd0 ? DONE : WRITE;
         WRITE:      if (last) nxt = GAP;
         GAP:        nxt = READ;
         READ:       if (last) nxt = DRAIN;
         DRAIN:      if (drained || tmo_hit) nxt = DONE;
         default:    nxt = IDLE;
      endcase
   end
   always_comb begin
      cur_addr = base + CTRL_ADDR_WIDTH'(idx);
      busy     = state inside {WRITE, GAP, READ, DRAIN};
      done     = state == DONE;
      wen      = state == WRITE;
      ren      = state == READ;
      wb       = {MEM_DQ_WIDTH{wen}};
      waddr    = wen ? cur_addr : '0;
      raddr    = ren ? cur_addr : '0;
      wdin     = wen ? tg_pattern(seed_q, cur_addr) : '0;
      err      = chk_err || timeout;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         base    <= '0;
         nw      <= '0;
         seed_q  <= '0;
         idx     <= '0;
         timer   <= '0;
         timeout <= 1'b0;
      end else begin
         if (start_ok) begin
            base    <= start_addr;
            nw      <= num_words;
            seed_q  <= seed;
            idx     <= '0;
            timeout <= 1'b0;
         end
         if (state == WRITE || state == READ) idx <= last ? '0 : idx + 16'd1;
         timer <= (state == DRAIN && !rvld) ? timer + TW'(1) : '0;
         if (tmo_hit) timeout <= 1'b1;
      end
   mem_tg_checker u_chk (
      .clk(clk), .rst(rst), .clr(start_ok), .active(state == READ || state == DRAIN),
      .base(base), .nw(nw), .seed(seed_q), .rvld(rvld), .rdout(rdout),
      .chk_idx(chk_idx), .err(chk_err), .err_cnt(err_cnt)
`ifdef TG_ERR_LOG_EN
      , .first_err_addr(first_err_addr), .first_err_data(first_err_data)
`endif
   );
endmodule
